fetch_queue: RTL and testbench

Instruction queue on the consumer side of the fetch unit's valid/ready output interface. It accepts fetched packets (instr, pc, pc_4) when fetch asserts valid, and drives ready back to fetch. Packets are presented in order to decode/rename with their own valid/ready handshake. On mispredict it discards every buffered packet, so only post-redirect instructions reach the backend.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order ring buffer between fetch and decode; a mispredict empties it and
// drops the packet offered in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = fetch_queue_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mispredict,
    input  logic                       valid_in,
    input  logic [XLEN-1:0]            instr_in,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [XLEN-1:0]            pc_4_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [XLEN-1:0]            instr_out,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_4_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_pkt_t      mem [DEPTH];
    fetch_pkt_t      pkt_in;
    fetch_pkt_t      pkt_head;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            push;
    logic            pop;

    assign pkt_in = '{instr: instr_in, pc: pc_in, pc_4: pc_4_in};

    // ready_out looks only at registered occupancy so fetch never sees a
    // combinational path from decode's ready_in.
    assign ready_out = (count != CW'(DEPTH));
    assign valid_out = (count != '0) && !mispredict;
    assign push      = valid_in && ready_out && !mispredict;
    assign pop       = valid_out && ready_in;

    assign pkt_head  = mem[head];
    assign instr_out = pkt_head.instr;
    assign pc_out    = pkt_head.pc;
    assign pc_4_out  = pkt_head.pc_4;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mispredict) begin
            // Contents are left stale; pointers alone define what is live.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= pkt_in;
                tail      <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset, mispredict, valid_in, ready_in;
    logic [W-1:0]  instr_in, pc_in, pc_4_in;
    logic          ready_out, valid_out;
    logic [W-1:0]  instr_out, pc_out, pc_4_out;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(W)) dut (
        .clk(clk), .reset(reset), .mispredict(mispredict),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .pc_4_in(pc_4_in),
        .ready_out(ready_out), .valid_out(valid_out),
        .instr_out(instr_out), .pc_out(pc_out), .pc_4_out(pc_4_out),
        .ready_in(ready_in), .count(count)
    );

    always #5 clk = ~clk;

    fetch_pkt_t q[$];
    bit         z_known;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check outputs against the model, clock, update model.
    task automatic step(input bit v, input logic [W-1:0] ins, input logic [W-1:0] pc,
                        input bit rdy, input bit mp, input bit rst, output bit acc);
        fetch_pkt_t pkt;
        bit exp_v, exp_r, do_pop, do_push;
        valid_in = v; instr_in = ins; pc_in = pc; pc_4_in = pc + 32'd4;
        ready_in = rdy; mispredict = mp; reset = rst;
        pkt = '{instr: ins, pc: pc, pc_4: pc + 32'd4};
        #1;
        exp_v = (q.size() != 0) && !mp;
        exp_r = (q.size() != DEPTH);
        chk("valid_out", W'(valid_out), W'(exp_v));
        chk("ready_out", W'(ready_out), W'(exp_r));
        chk("count", W'(count), W'(q.size()));
        if (q.size() != 0) begin
            chk("instr_out", instr_out, q[0].instr);
            chk("pc_out", pc_out, q[0].pc);
            chk("pc_4_out", pc_4_out, q[0].pc_4);
        end else if (z_known) begin
            chk("instr_out_zero", instr_out, '0);
            chk("pc_out_zero", pc_out, '0);
            chk("pc_4_out_zero", pc_4_out, '0);
        end
        do_pop  = exp_v && rdy;
        do_push = v && exp_r && !mp;
        @(posedge clk);
        if (rst) begin
            q.delete();
            z_known = 1'b1;
        end else if (mp) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(pkt);
                z_known = 1'b0;
            end
        end
        acc = do_push && !rst;
        #1;
    endtask

    initial begin
        bit          acc;
        int          budget;
        logic [W-1:0] rpc;
        logic [W-1:0] insv [3];
        insv[0] = 32'h00000013; insv[1] = 32'h00100093; insv[2] = 32'h00200113;

        reset = 1'b1; mispredict = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        instr_in = '0; pc_in = '0; pc_4_in = '0;
        repeat (2) @(posedge clk);
        #1;
        z_known = 1'b1;

        // Streaming with decode always ready
        for (int i = 0; i < 3; i++) step(1, insv[i], 32'(i*4), 1, 0, 0, acc);
        step(0, '0, '0, 1, 0, 0, acc);
        step(0, '0, '0, 1, 0, 0, acc);

        // Fill with decode stalled, 5th offer refused, then drain
        for (int i = 0; i < 4; i++) step(1, 32'h1000 + 32'(i), 32'(i*4), 0, 0, 0, acc);
        step(1, 32'h1004, 32'h10, 0, 0, 0, acc);
        chk("full_refuse", W'(acc), '0);
        acc = 0; budget = 0;
        while (!acc && budget < 10) begin
            step(1, 32'h1004, 32'h10, 1, 0, 0, acc);
            budget++;
        end
        chk("hold_accept", W'(acc), W'(1));
        repeat (6) step(0, '0, '0, 1, 0, 0, acc);

        // Steady push+pop at count=2 wrapping the pointers
        step(1, 32'h2000, 32'h100, 0, 0, 0, acc);
        step(1, 32'h2001, 32'h104, 0, 0, 0, acc);
        for (int i = 0; i < 6; i++) step(1, 32'h2002 + 32'(i), 32'h108 + 32'(i*4), 1, 0, 0, acc);
        chk("steady_count", W'(count), W'(2));
        repeat (3) step(0, '0, '0, 1, 0, 0, acc);

        // Flush with a packet on the input, packet re-offered afterwards
        step(1, 32'h3004, 32'h4, 0, 0, 0, acc);
        step(1, 32'h3008, 32'h8, 0, 0, 0, acc);
        step(1, 32'h3040, 32'h40, 1, 1, 0, acc);
        chk("flush_drop", W'(acc), '0);
        step(1, 32'h3040, 32'h40, 1, 0, 0, acc);
        step(1, 32'h3044, 32'h44, 1, 0, 0, acc);
        step(1, 32'h3048, 32'h48, 1, 0, 0, acc);
        repeat (2) step(0, '0, '0, 1, 0, 0, acc);

        // Full queue hit by reset together with mispredict
        for (int i = 0; i < 4; i++) step(1, 32'h4000 + 32'(i), 32'h200 + 32'(i*4), 0, 0, 0, acc);
        step(1, 32'h5000, 32'h300, 0, 1, 1, acc);
        step(0, '0, '0, 0, 0, 0, acc);

        // Randomized traffic
        rpc = 32'h8000;
        for (int i = 0; i < 2000; i++) begin
            bit v, r, m, rs;
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            m  = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 999) < 2);
            step(v, $urandom, rpc, r, m, rs, acc);
            if (acc) rpc = rpc + 32'd4;
        end
        repeat (6) step(0, '0, '0, 1, 0, 0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
